// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single register-file write port between NUM_REQ writeback
// sources. Round-robin arbitration with optional burst locking of the last
// winner, followed by a one-cycle registered output stage.
// Optional build macro: REGARB_ZERO_FILTER_EN (suppress writes to $zero).
module regfile_write_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int MAX_BURST = 4
) (
    input  logic                    Clock,
    input  logic                    reset,
    input  logic                    wr_stall,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      lock,
    input  logic [5*NUM_REQ-1:0]    addr_flat,
    input  logic [32*NUM_REQ-1:0]   data_flat,
    output logic [NUM_REQ-1:0]      grant,
    output logic                    RegWrite,
    output logic [4:0]              Address3Write,
    output logic [31:0]             WriteData,
    output logic [2:0]              owner
);

    typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;

    state_t               state, state_nx;
    logic [2:0]           rr_ptr, rr_nx;
    logic [3:0]           burst_cnt, cnt_nx;
    logic                 xfer_p0;
    logic [2:0]           gidx_p0;
    logic [4:0]           addr_p0;
    logic [31:0]          data_p0;
    logic                 wen_p0;
    logic                 own_req, own_lock;
    logic [NUM_REQ-1:0]   own_mask, arb_req;
    logic [3:0]           pick;
    logic [5*NUM_REQ-1:0] addr_sh;
    logic [32*NUM_REQ-1:0] data_sh;

    // Bit idx of a requester vector, via shift to keep index widths exact.
    function automatic logic bit_at(input logic [NUM_REQ-1:0] v, input logic [2:0] idx);
        logic [NUM_REQ-1:0] sh;
        sh = v >> idx;
        return sh[0];
    endfunction

    // First set bit of r scanning upward from ptr with wrap; {found, index}.
    function automatic logic [3:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [2:0] ptr);
        logic [3:0] res;
        int         j;
        res = 4'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (bit_at(r, 3'(j))) res = {1'b1, 3'(j)};
        end
        return res;
    endfunction

    // Arbitration: locked owner first while its burst lasts, else round-robin.
    always_comb begin
        xfer_p0  = 1'b0;
        gidx_p0  = 3'd0;
        state_nx = state;
        rr_nx    = rr_ptr;
        cnt_nx   = burst_cnt;
        own_req  = bit_at(req, owner);
        own_lock = bit_at(lock, owner);
        own_mask = NUM_REQ'(1) << owner;
        arb_req  = req;
        pick     = 4'd0;
        if (reset && !wr_stall) begin
            if (state == LOCKED && own_req && own_lock && burst_cnt < 4'(MAX_BURST)) begin
                xfer_p0 = 1'b1;
                gidx_p0 = owner;
                cnt_nx  = burst_cnt + 4'd1;
            end else begin
                // An exhausted burst owner yields unless nobody else is asking.
                if (state == LOCKED && own_req && own_lock && (req & ~own_mask) != '0)
                    arb_req = req & ~own_mask;
                pick     = rr_pick(arb_req, rr_ptr);
                state_nx = ARB;
                cnt_nx   = 4'd0;
                if (pick[3]) begin
                    xfer_p0 = 1'b1;
                    gidx_p0 = pick[2:0];
                    rr_nx   = (pick[2:0] == 3'(NUM_REQ - 1)) ? 3'd0 : pick[2:0] + 3'd1;
                    if (bit_at(lock, pick[2:0])) begin
                        state_nx = LOCKED;
                        cnt_nx   = 4'd1;
                    end
                end
            end
        end
        grant = xfer_p0 ? (NUM_REQ'(1) << gidx_p0) : '0;
    end

    // Route the winner's address and data toward the output stage.
    always_comb begin
        addr_sh = addr_flat >> (5 * int'(gidx_p0));
        data_sh = data_flat >> (32 * int'(gidx_p0));
        addr_p0 = addr_sh[4:0];
        data_p0 = data_sh[31:0];
    end

`ifdef REGARB_ZERO_FILTER_EN
    assign wen_p0 = xfer_p0 && (addr_p0 != 5'd0);
`else
    assign wen_p0 = xfer_p0;
`endif

    // Arbiter state: FSM, round-robin pointer, burst counter, last owner.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state     <= ARB;
            rr_ptr    <= 3'd0;
            burst_cnt <= 4'd0;
            owner     <= 3'd0;
        end else begin
            state     <= state_nx;
            rr_ptr    <= rr_nx;
            burst_cnt <= cnt_nx;
            if (xfer_p0) owner <= gidx_p0;
        end
    end

    // ---- stage p0 -> register-file write port ----
    // Output stage: one-cycle registered write, address/data hold when idle.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            RegWrite      <= 1'b0;
            Address3Write <= 5'd0;
            WriteData     <= 32'd0;
        end else begin
            RegWrite <= wen_p0;
            if (xfer_p0) begin
                Address3Write <= addr_p0;
                WriteData     <= data_p0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed scenarios followed by random
// traffic, all checked against a behavioural arbiter model.
module tb_regfile_write_arbiter;

    localparam int NR   = 3;
    localparam int MAXB = 4;
`ifdef REGARB_ZERO_FILTER_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic            Clock;
    logic            reset;
    logic            wr_stall;
    logic [NR-1:0]   req;
    logic [NR-1:0]   lock;
    logic [5*NR-1:0] addr_flat;
    logic [32*NR-1:0] data_flat;
    logic [NR-1:0]   grant;
    logic            RegWrite;
    logic [4:0]      Address3Write;
    logic [31:0]     WriteData;
    logic [2:0]      owner;

    regfile_write_arbiter #(.NUM_REQ(NR), .MAX_BURST(MAXB)) dut (
        .Clock(Clock), .reset(reset), .wr_stall(wr_stall), .req(req), .lock(lock),
        .addr_flat(addr_flat), .data_flat(data_flat), .grant(grant),
        .RegWrite(RegWrite), .Address3Write(Address3Write), .WriteData(WriteData),
        .owner(owner)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Model state
    bit          m_locked;
    int          m_ptr, m_cnt, m_owner, last_k;
    bit          m_rw;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic bit bitof(input logic [NR-1:0] v, input int i);
        return ((v >> i) & NR'(1)) != '0;
    endfunction

    function automatic logic [4:0] addr_of(input int k);
        return 5'(addr_flat >> (5 * k));
    endfunction

    function automatic logic [31:0] data_of(input int k);
        return 32'(data_flat >> (32 * k));
    endfunction

    function automatic void model_reset();
        m_locked = 0; m_ptr = 0; m_cnt = 0; m_owner = 0;
        m_rw = 0; m_addr = 5'd0; m_data = 32'd0; last_k = -1;
    endfunction

    // Which requester should win this cycle (-1 for none).
    function automatic int model_pick();
        int excl;
        excl = -1;
        if (wr_stall) return -1;
        if (m_locked && bitof(req, m_owner) && bitof(lock, m_owner)) begin
            if (m_cnt < MAXB) return m_owner;
            excl = m_owner;
        end
        for (int i = 0; i < NR; i++) begin
            int j;
            j = (m_ptr + i) % NR;
            if (bitof(req, j) && j != excl) return j;
        end
        if (excl >= 0) return excl;
        return -1;
    endfunction

    function automatic void model_update(input int k);
        bit burst;
        if (wr_stall) begin m_rw = 0; last_k = -1; return; end
        if (k < 0) begin m_locked = 0; m_cnt = 0; m_rw = 0; last_k = -1; return; end
        burst = m_locked && bitof(req, m_owner) && bitof(lock, m_owner) && m_cnt < MAXB;
        if (burst) m_cnt++;
        else begin
            m_ptr    = (k + 1) % NR;
            m_locked = bitof(lock, k);
            m_cnt    = m_locked ? 1 : 0;
        end
        m_owner = k;
        m_addr  = addr_of(k);
        m_data  = data_of(k);
        m_rw    = !(ZF && m_addr == 5'd0);
        last_k  = k;
    endfunction

    task automatic refresh(input int k);
        logic [4:0]  a;
        logic [31:0] d;
        a = 5'($urandom_range(0, 31));
        d = $urandom;
        addr_flat = (addr_flat & ~(15'h1f << (5 * k))) | (15'(a) << (5 * k));
        data_flat = (data_flat & ~(96'hffffffff << (32 * k))) | (96'(d) << (32 * k));
    endtask

    // One clock: inputs already applied at posedge+1; check, clock, update model.
    task automatic step(input string tag, input bit stall_i);
        int k;
        logic [NR-1:0] eg;
        wr_stall = stall_i;
        #2;
        k  = model_pick();
        eg = (k >= 0) ? NR'(1 << k) : '0;
        check({tag, ".grant"}, 32'(grant), 32'(eg));
        check({tag, ".RegWrite"}, 32'(RegWrite), 32'(m_rw));
        check({tag, ".Address3Write"}, 32'(Address3Write), 32'(m_addr));
        check({tag, ".WriteData"}, WriteData, m_data);
        check({tag, ".owner"}, 32'(owner), 32'(m_owner));
        @(posedge Clock);
        #1;
        model_update(k);
    endtask

    // Random requester behaviour honouring the hold-until-granted handshake.
    task automatic gen_random();
        for (int j = 0; j < NR; j++) begin
            if (!bitof(req, j) || j == last_k) begin
                if ($urandom_range(0, 9) < 7) begin
                    req = req | NR'(1 << j);
                    refresh(j);
                    if ($urandom_range(0, 2) == 0) lock = lock | NR'(1 << j);
                    else                           lock = lock & ~NR'(1 << j);
                end else begin
                    req  = req & ~NR'(1 << j);
                    lock = lock & ~NR'(1 << j);
                end
            end else if ($urandom_range(0, 7) == 0) begin
                lock = lock ^ NR'(1 << j);
            end
        end
    endtask

    initial begin
        reset = 1'b0; wr_stall = 1'b0; req = 3'b111; lock = 3'b000;
        addr_flat = '0; data_flat = '0;
        for (int j = 0; j < NR; j++) refresh(j);
        model_reset();

        // Reset: requests pending but nothing granted or written.
        @(posedge Clock); #1;
        check("rst.grant", 32'(grant), 32'h0);
        check("rst.RegWrite", 32'(RegWrite), 32'h0);
        check("rst.Address3Write", 32'(Address3Write), 32'h0);
        check("rst.WriteData", WriteData, 32'h0);
        check("rst.owner", 32'(owner), 32'h0);
        @(posedge Clock); #1;
        reset = 1'b1;

        // Round-robin with all requesters active, no lock.
        for (int n = 0; n < 7; n++) begin
            step("rr", 1'b0);
            if (last_k >= 0) refresh(last_k);
        end

        // Burst lock on requester 1 with competition.
        lock = 3'b010;
        for (int n = 0; n < 14; n++) begin
            step("burst", 1'b0);
            if (last_k >= 0) refresh(last_k);
        end

        // Stall mid-stream.
        lock = 3'b000; req = 3'b011;
        for (int n = 0; n < 8; n++) begin
            step("stall", (n >= 2 && n < 5));
            if (last_k >= 0) refresh(last_k);
        end

        // Reset in the middle of a locked burst.
        req = 3'b010; lock = 3'b010;
        for (int n = 0; n < 3; n++) begin
            step("lockrun", 1'b0);
            if (last_k >= 0) refresh(last_k);
        end
        reset = 1'b0;
        #1;
        check("midrst.RegWrite", 32'(RegWrite), 32'h0);
        check("midrst.grant", 32'(grant), 32'h0);
        model_reset();
        @(posedge Clock); #1;
        reset = 1'b1;
        req = 3'b011; lock = 3'b000;
        step("postrst", 1'b0);
        step("postrst", 1'b0);

        // Write to address 0.
        req = 3'b001; lock = 3'b000;
        addr_flat[4:0] = 5'd0;
        data_flat[31:0] = 32'hDEADBEEF;
        step("zero", 1'b0);
        req = 3'b000;
        step("zero", 1'b0);
        check("zero.addr", 32'(m_addr), 32'h0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            gen_random();
            step("rand", ($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
